plot_arbiter: RTL and testbench

//  Shares the single vga_adapter plot port between two drawing engines: background tile redraw (bg) and

---
 rtl/plot_arbiter.sv | 115 +++++++++++
 tb/tb_plot_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/plot_arbiter.sv
// Arbitrates the single vga_adapter plot port between the bg and fg drawing engines, with a watchdog on stalled grants.
// Optional `FG_PRIORITY_EN: fg always wins an IDLE decision (default build: round-robin).
module plot_arbiter #(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int COL_W   = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             bg_req,
  input  logic             bg_done,
  input  logic             bg_plot,
  input  logic [X_W-1:0]   bg_x,
  input  logic [Y_W-1:0]   bg_y,
  input  logic [COL_W-1:0] bg_colour,
  input  logic             fg_req,
  input  logic             fg_done,
  input  logic             fg_plot,
  input  logic [X_W-1:0]   fg_x,
  input  logic [Y_W-1:0]   fg_y,
  input  logic [COL_W-1:0] fg_colour,
  output logic             gnt_bg,
  output logic             gnt_fg,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             plot,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, GNT_BG, GNT_FG} state_t;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, next_state;
  logic             last_fg, next_last_fg;
  logic [CNT_W-1:0] wd_count;

  logic             own_req, own_plot, own_done;
  logic [X_W-1:0]   own_x;
  logic [Y_W-1:0]   own_y;
  logic [COL_W-1:0] own_colour;
  logic             granted, fire, finish, wd_expire;

  // Mux the owning engine's signals; the other engine is invisible to the datapath.
  assign own_req    = (state == GNT_FG) ? fg_req    : bg_req;
  assign own_plot   = (state == GNT_FG) ? fg_plot   : bg_plot;
  assign own_done   = (state == GNT_FG) ? fg_done   : bg_done;
  assign own_x      = (state == GNT_FG) ? fg_x      : bg_x;
  assign own_y      = (state == GNT_FG) ? fg_y      : bg_y;
  assign own_colour = (state == GNT_FG) ? fg_colour : bg_colour;

  assign granted   = (state != IDLE);
  assign fire      = granted & own_plot;
  assign finish    = fire & own_done;
  assign wd_expire = granted & (wd_count == WD_LAST) & ~finish;

  assign gnt_bg = (state == GNT_BG);
  assign gnt_fg = (state == GNT_FG);
  assign busy   = gnt_bg | gnt_fg;

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state   = state;
    next_last_fg = last_fg;
    unique case (state)
      IDLE: begin
`ifdef FG_PRIORITY_EN
        if (fg_req)      next_state = GNT_FG;
        else if (bg_req) next_state = GNT_BG;
`else
        if (bg_req && fg_req) next_state = last_fg ? GNT_BG : GNT_FG;
        else if (bg_req)      next_state = GNT_BG;
        else if (fg_req)      next_state = GNT_FG;
`endif
      end
      GNT_BG, GNT_FG: begin
        if (finish || !own_req || wd_expire) begin
          next_state   = IDLE;
          next_last_fg = (state == GNT_FG);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      last_fg     <= 1'b1;
      wd_count    <= '0;
      timeout_err <= 1'b0;
      plot        <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
    end else begin
      state    <= next_state;
      last_fg  <= next_last_fg;
      wd_count <= granted ? wd_count + 1'b1 : '0;
      if (wd_expire) timeout_err <= 1'b1;
      plot <= fire;
      if (fire) begin
        x      <= own_x;
        y      <= own_y;
        colour <= own_colour;
      end
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter: directed scenarios then randomized traffic against a cycle-level owner model.
module tb_plot_arbiter;

  localparam int X_W = 10, Y_W = 9, COL_W = 3, TIMEOUT = 8;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic bg_req = 0, bg_done = 0, bg_plot = 0;
  logic fg_req = 0, fg_done = 0, fg_plot = 0;
  logic [X_W-1:0]   bg_x = '0, fg_x = '0;
  logic [Y_W-1:0]   bg_y = '0, fg_y = '0;
  logic [COL_W-1:0] bg_colour = '0, fg_colour = '0;
  logic gnt_bg, gnt_fg, plot, busy, timeout_err;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [COL_W-1:0] colour;

  plot_arbiter #(.X_W(X_W), .Y_W(Y_W), .COL_W(COL_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .resetn(resetn),
    .bg_req(bg_req), .bg_done(bg_done), .bg_plot(bg_plot), .bg_x(bg_x), .bg_y(bg_y), .bg_colour(bg_colour),
    .fg_req(fg_req), .fg_done(fg_done), .fg_plot(fg_plot), .fg_x(fg_x), .fg_y(fg_y), .fg_colour(fg_colour),
    .gnt_bg(gnt_bg), .gnt_fg(gnt_fg), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: owner 0=none 1=bg 2=fg, held = granted cycles so far without finishing.
  int m_owner, m_held, m_last;
  bit m_plot, m_err;
  logic [X_W-1:0]   m_x;
  logic [Y_W-1:0]   m_y;
  logic [COL_W-1:0] m_col;
  int grant_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_held = 0; m_last = 2;
    m_plot = 0; m_err = 0; m_x = '0; m_y = '0; m_col = '0;
  endtask

  task automatic model_edge();
    int own;
    bit r, p, d, wd;
    own = m_owner;
    r = 0; p = 0; d = 0;
    if (own == 1) begin
      r = bg_req; p = bg_plot; d = bg_plot && bg_done;
    end else if (own == 2) begin
      r = fg_req; p = fg_plot; d = fg_plot && fg_done;
    end
    m_plot = p;
    if (p) begin
      m_x   = (own == 1) ? bg_x : fg_x;
      m_y   = (own == 1) ? bg_y : fg_y;
      m_col = (own == 1) ? bg_colour : fg_colour;
    end
    if (own != 0) begin
      wd = (m_held == TIMEOUT - 1) && !d;
      if (d || !r || wd) begin
        m_owner = 0;
        m_last  = own;
        if (wd) m_err = 1;
      end else begin
        m_held++;
      end
    end else begin
      m_held = 0;
`ifdef FG_PRIORITY_EN
      if (fg_req)      m_owner = 2;
      else if (bg_req) m_owner = 1;
`else
      if (bg_req && fg_req) m_owner = (m_last == 1) ? 2 : 1;
      else if (bg_req)      m_owner = 1;
      else if (fg_req)      m_owner = 2;
`endif
      if (m_owner != 0) grant_log.push_back(m_owner);
    end
  endtask

  task automatic compare_all();
    check("gnt_bg", 32'(gnt_bg), 32'(m_owner == 1));
    check("gnt_fg", 32'(gnt_fg), 32'(m_owner == 2));
    check("busy", 32'(busy), 32'(m_owner != 0));
    check("plot", 32'(plot), 32'(m_plot));
    check("x", 32'(x), 32'(m_x));
    check("y", 32'(y), 32'(m_y));
    check("colour", 32'(colour), 32'(m_col));
    check("timeout_err", 32'(timeout_err), 32'(m_err));
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic quiet_inputs();
    bg_req = 0; bg_done = 0; bg_plot = 0;
    fg_req = 0; fg_done = 0; fg_plot = 0;
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must clear before any edge.
  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    #2;
    compare_all();
    quiet_inputs();
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    int cnt, bg_cnt, fg_cnt;
    model_reset();
    @(posedge clock);
    #1;
    do_reset();

    // 1: single bg burst of four pixels ending with done.
    bg_req = 1;
    step();
    check("s1_grant", 32'(gnt_bg), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bg_plot = 1; bg_x = X_W'(10 + i); bg_y = 9'd20; bg_colour = 3'd3; bg_done = (i == 3);
      step();
    end
    check("s1_last_x", 32'(x), 32'd13);
    check("s1_release", 32'(gnt_bg), 32'd0);
    quiet_inputs();
    step();

    // 2: both request from reset, two-pixel bursts each.
    @(negedge clock);
    do_reset();
    grant_log.delete();
    bg_req = 1; fg_req = 1; bg_cnt = 0; fg_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      bg_plot = (m_owner == 1); bg_done = (m_owner == 1) && (bg_cnt == 1);
      fg_plot = (m_owner == 2); fg_done = (m_owner == 2) && (fg_cnt == 1);
      bg_x = X_W'($urandom); fg_x = X_W'($urandom);
      bg_cnt = (m_owner == 1) ? bg_cnt + 1 : 0;
      fg_cnt = (m_owner == 2) ? fg_cnt + 1 : 0;
      step();
    end
    check("s2_grants", 32'(grant_log.size() >= 4), 32'd1);
    if (grant_log.size() >= 4) begin
`ifdef FG_PRIORITY_EN
      check("s2_order", 32'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]} == {32'd2, 32'd2, 32'd2, 32'd2}), 32'd1);
`else
      check("s2_order", 32'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]} == {32'd1, 32'd2, 32'd1, 32'd2}), 32'd1);
`endif
    end

    // 3: fg granted, never done -> watchdog revoke after TIMEOUT cycles; pending bg then wins.
    do_reset();
    fg_req = 1;
    step();
    bg_req = 1;
    cnt = (gnt_fg === 1'b1) ? 1 : 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      if (gnt_fg === 1'b1) cnt++;
    end
    check("s3_held_cycles", 32'(cnt), 32'(TIMEOUT));
    check("s3_err", 32'(timeout_err), 32'd1);
`ifndef FG_PRIORITY_EN
    step();
    check("s3_bg_next", 32'(gnt_bg), 32'd1);

    // 4: fg plots while bg owns the port.
    bg_plot = 1; bg_x = 10'd100; fg_plot = 1; fg_x = 10'd5;
    step();
    check("s4_x_bg", 32'(x), 32'd100);
    bg_plot = 0;
    step();
    check("s4_x_hold", 32'(x), 32'd100);
    check("s4_err_sticky", 32'(timeout_err), 32'd1);

    // 5: reset mid-bg-burst, then the tie goes to bg again.
    bg_plot = 1; fg_plot = 0;
    #2;
    do_reset();
    bg_req = 1; fg_req = 1;
    step();
    check("s5_tie_bg", 32'(gnt_bg), 32'd1);

    // 6: bg drops req mid-burst with fg pending.
    bg_plot = 1; bg_x = 10'd77;
    step();
    bg_req = 0; bg_plot = 0;
    step();
    check("s6_idle", 32'(busy), 32'd0);
    step();
    check("s6_fg", 32'(gnt_fg), 32'd1);
    check("s6_no_err", 32'(timeout_err), 32'd0);
`endif

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bg_req    = ($urandom_range(0, 9) != 0);
      fg_req    = ($urandom_range(0, 9) != 0);
      bg_plot   = $urandom_range(0, 1);
      fg_plot   = $urandom_range(0, 1);
      bg_done   = ($urandom_range(0, 5) == 0);
      fg_done   = ($urandom_range(0, 5) == 0);
      bg_x      = X_W'($urandom); bg_y = Y_W'($urandom); bg_colour = COL_W'($urandom);
      fg_x      = X_W'($urandom); fg_y = Y_W'($urandom); fg_colour = COL_W'($urandom);
      if (i % 400 == 399) begin
        #2;
        do_reset();
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
